// File: rtl/swerv_trace_fifo.sv
// Retirement-trace FIFO: splits each 3-slot trace bundle into per-slot records and streams them out FWFT.
// Optional macro SWERV_TRACE_DROP_CNT_EN enables the saturating dropped-bundle counter on drop_cnt.
module swerv_trace_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trace_en,
    input  logic [2:0]    trace_rv_i_valid_ip,
    input  logic [95:0]   trace_rv_i_insn_ip,
    input  logic [95:0]   trace_rv_i_address_ip,
    input  logic [2:0]    trace_rv_i_exception_ip,
    input  logic [4:0]    trace_rv_i_ecause_ip,
    input  logic [2:0]    trace_rv_i_interrupt_ip,
    input  logic [31:0]   trace_rv_i_tval_ip,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [104:0]  out_data,
    output logic          ovf_sticky,
    input  logic          ovf_clr,
    output logic [15:0]   drop_cnt,
    output logic [AW:0]   occupancy
);

    localparam int unsigned RW = 105;
    localparam int unsigned NS = 3;

    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic [NS-1:0] vmask;
    logic [1:0]    nv;
    logic [AW:0]   free;
    logic          accept;
    logic          drop;
    logic          pop;
    logic [AW-1:0] off [NS];
    logic [RW-1:0] rec [NS];

    // Push decision uses the registered occupancy only; a same-cycle pop earns no credit.
    always_comb begin
        vmask  = trace_rv_i_valid_ip & {NS{trace_en}};
        nv     = 2'(vmask[0]) + 2'(vmask[1]) + 2'(vmask[2]);
        free   = (AW+1)'(DEPTH) - occupancy;
        accept = (nv != 2'd0) && ((AW+1)'(nv) <= free);
        drop   = (nv != 2'd0) && !accept;
        pop    = out_valid && out_ready;
    end

    // Per-slot write offset packs valid slots into consecutive entries, slot 0 first.
    always_comb begin
        off[0] = '0;
        off[1] = AW'(vmask[0]);
        off[2] = AW'(vmask[0]) + AW'(vmask[1]);
        for (int s = 0; s < NS; s++) begin
            rec[s] = {2'(s), trace_rv_i_exception_ip[s], trace_rv_i_interrupt_ip[s],
                      trace_rv_i_ecause_ip, trace_rv_i_tval_ip,
                      trace_rv_i_address_ip[32*s +: 32], trace_rv_i_insn_ip[32*s +: 32]};
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int s = 0; s < NS; s++) begin
                if (vmask[s]) begin
                    mem[AW'(wr_ptr + off[s])] <= rec[s];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + AW'(nv);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            occupancy <= occupancy + (accept ? (AW+1)'(nv) : (AW+1)'(0)) - (AW+1)'(pop);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    assign out_valid = (occupancy != '0);
    assign out_data  = mem[rd_ptr];

`ifdef SWERV_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_swerv_trace_fifo.sv
// Directed self-checking bench for swerv_trace_fifo (DEPTH=16).
module tb_swerv_trace_fifo;

`ifdef SWERV_TRACE_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          trace_en;
    logic [2:0]    valid;
    logic [95:0]   insn;
    logic [95:0]   addr;
    logic [2:0]    exc;
    logic [4:0]    ecause;
    logic [2:0]    intr;
    logic [31:0]   tval;
    logic          out_valid;
    logic          out_ready;
    logic [104:0]  out_data;
    logic          ovf_sticky;
    logic          ovf_clr;
    logic [15:0]   drop_cnt;
    logic [4:0]    occupancy;

    int n_tests = 0;
    int n_fail  = 0;

    swerv_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .trace_en                (trace_en),
        .trace_rv_i_valid_ip     (valid),
        .trace_rv_i_insn_ip      (insn),
        .trace_rv_i_address_ip   (addr),
        .trace_rv_i_exception_ip (exc),
        .trace_rv_i_ecause_ip    (ecause),
        .trace_rv_i_interrupt_ip (intr),
        .trace_rv_i_tval_ip      (tval),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .ovf_sticky              (ovf_sticky),
        .ovf_clr                 (ovf_clr),
        .drop_cnt                (drop_cnt),
        .occupancy               (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [104:0] mk(input logic [1:0] s, input logic e, input logic i,
                                        input logic [4:0] c, input logic [31:0] tv,
                                        input logic [31:0] a, input logic [31:0] ins);
        return {s, e, i, c, tv, a, ins};
    endfunction

    // Advance one edge; inputs are then changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;
        int mocc;
        int cyc;
        rst = 1'b1; trace_en = 1'b1; valid = '0; insn = '0; addr = '0; exc = '0;
        ecause = '0; intr = '0; tval = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_occ", 128'(occupancy), 128'd0);
        check("rst_ovf", 128'(ovf_sticky), 128'd0);
        check("rst_drop", 128'(drop_cnt), 128'd0);

        // Two-slot bundle, streamed straight out.
        valid = 3'b011; out_ready = 1'b1;
        insn = {32'h0, 32'h00A00093, 32'h00100013};
        addr = {32'h0, 32'h104, 32'h100};
        step();
        valid = 3'b000;
        check("t1_valid", 128'(out_valid), 128'd1);
        check("t1_rec0", 128'(out_data), 128'(mk(2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h100, 32'h00100013)));
        step();
        check("t1_rec1", 128'(out_data), 128'(mk(2'd1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h104, 32'h00A00093)));
        check("t1_occ1", 128'(occupancy), 128'd1);
        step();
        check("t1_occ0", 128'(occupancy), 128'd0);
        check("t1_empty", 128'(out_valid), 128'd0);

        // Fill with 3-slot bundles, stalled sink.
        out_ready = 1'b0; valid = 3'b111;
        insn = {32'hC, 32'hB, 32'hA};
        addr = {32'h208, 32'h204, 32'h200};
        for (int b = 0; b < 5; b++) step();
        check("t2_occ15", 128'(occupancy), 128'd15);
        check("t2_head", 128'(out_data), 128'(mk(2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h200, 32'hA)));
        valid = 3'b001;
        step();
        check("t2_occ16", 128'(occupancy), 128'd16);
        check("t2_noovf", 128'(ovf_sticky), 128'd0);
        valid = 3'b111;
        step();
        check("t2_full_occ", 128'(occupancy), 128'd16);
        check("t2_ovf", 128'(ovf_sticky), 128'd1);
        check("t2_drop", 128'(drop_cnt), CNT_EN ? 128'd1 : 128'd0);
        valid = 3'b000; ovf_clr = 1'b1;
        step();
        check("t2_clr", 128'(ovf_sticky), 128'd0);
        valid = 3'b111;
        step();
        check("t2_clr_vs_drop", 128'(ovf_sticky), 128'd1);
        check("t2_drop2", 128'(drop_cnt), CNT_EN ? 128'd2 : 128'd0);
        ovf_clr = 1'b0;

        // Occupancy 14 with a same-cycle pop: 3-slot push still drops.
        valid = 3'b000; out_ready = 1'b1;
        step(); step();
        check("t3_occ14", 128'(occupancy), 128'd14);
        valid = 3'b111;
        step();
        valid = 3'b000;
        check("t3_occ13", 128'(occupancy), 128'd13);
        check("t3_drop3", 128'(drop_cnt), CNT_EN ? 128'd3 : 128'd0);

        // Reset mid-stream at occupancy 7.
        for (int k = 0; k < 6; k++) step();
        check("t6_occ7", 128'(occupancy), 128'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_valid", 128'(out_valid), 128'd0);
        check("t6_occ", 128'(occupancy), 128'd0);
        check("t6_ovf", 128'(ovf_sticky), 128'd0);
        check("t6_drop", 128'(drop_cnt), 128'd0);

        // Slot 2 alone with exception, shared cause and tval.
        out_ready = 1'b0; valid = 3'b100; exc = 3'b100; ecause = 5'd2; tval = 32'hDEAD_BEEF;
        insn = {32'h00000073, 32'h1, 32'h2};
        addr = {32'h300, 32'h2FC, 32'h2F8};
        step();
        check("t4_occ", 128'(occupancy), 128'd1);
        check("t4_rec", 128'(out_data), 128'(mk(2'd2, 1'b1, 1'b0, 5'd2, 32'hDEAD_BEEF, 32'h300, 32'h00000073)));
        trace_en = 1'b0; valid = 3'b111;
        step();
        check("t4_en_off", 128'(occupancy), 128'd1);
        check("t4_en_nodrop", 128'(ovf_sticky), 128'd0);
        trace_en = 1'b1; valid = 3'b000; exc = '0; ecause = '0; tval = '0; out_ready = 1'b1;
        step();
        check("t4_drain", 128'(occupancy), 128'd0);

        // Pointer wrap: 40 single-slot records, sink toggling ready.
        sent = 0; got = 0; mocc = 0; cyc = 0;
        while (got < 40 && cyc < 2000) begin
            out_ready = cyc[0];
            if (sent < 40 && mocc < 16) begin
                valid = 3'b001;
                insn  = {64'h0, 32'(sent)};
                addr  = {64'h0, 32'h1000 + 32'(4 * sent)};
            end else begin
                valid = 3'b000;
            end
            if (mocc != 0) begin
                check("t5_valid", 128'(out_valid), 128'd1);
                check("t5_data", 128'(out_data),
                      128'(mk(2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h1000 + 32'(4 * got), 32'(got))));
            end
            if (out_ready && mocc != 0) begin
                got++;
                mocc--;
            end
            if (valid != 3'b000) begin
                sent++;
                mocc++;
            end
            step();
            cyc++;
            if (occupancy > 5'd16) check("t5_occ_max", 128'(occupancy), 128'd16);
        end
        valid = 3'b000;
        check("t5_all", 128'(got), 128'd40);
        check("t5_occ_end", 128'(occupancy), 128'd0);
        check("t5_noovf", 128'(ovf_sticky), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/swerv_trace_fifo.md
Name: swerv_trace_fifo

Overview:
- Consumes the per-cycle retirement trace bundle (trace_pkt_t fields) produced by the SweRV core.
- Splits each bundle into per-slot records, in order slot 0, then slot 1, then slot 2.
- Buffers the records in a FIFO and presents them one per cycle on a valid/ready stream.
- Sits between the core trace port and an off-core trace sink (debug UART/AXI trace writer).

Parameters:
- DEPTH, 16, number of record entries; power of 2, minimum 4.
- AW, 4, log2(DEPTH); occupancy counter is AW+1 bits.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- trace_en  in  1  capture enable; when 0, no records are pushed.
- trace_rv_i_valid_ip  in  3  per-slot valid.
- trace_rv_i_insn_ip  in  96  slot n instruction = bits [32n+31:32n].
- trace_rv_i_address_ip  in  96  slot n PC = bits [32n+31:32n].
- trace_rv_i_exception_ip  in  3  per-slot exception flag.
- trace_rv_i_ecause_ip  in  5  shared cause.
- trace_rv_i_interrupt_ip  in  3  per-slot interrupt flag.
- trace_rv_i_tval_ip  in  32  shared tval.
- out_valid  out  1  head record valid.
- out_ready  in  1  sink accepts head.
- out_data  out  105  record = {slot[1:0], exc, intr, ecause[4:0], tval[31:0], addr[31:0], insn[31:0]} (MSB to LSB).
- ovf_sticky  out  1  set on any dropped bundle.
- ovf_clr  in  1  clears ovf_sticky.
- drop_cnt  out  16  dropped-bundle count (see Optional Feature).
- occupancy  out  AW+1  current entry count.

Behaviour:
- Reset (rst=1 at a clk edge): FIFO empty; wr/rd pointers 0; out_valid=0; occupancy=0; ovf_sticky=0; drop_cnt=0. Reset mid-stream discards all entries.
- Push:
  - nv = popcount(valid & {3{trace_en}}).
  - Bundle accepted iff nv <= DEPTH - occupancy. Free space is computed from the registered occupancy only; a same-cycle pop is NOT credited.
  - Accepted: valid slots are written to consecutive entries in ascending slot order (wr_ptr, wr_ptr+1, ...). Pointers wrap modulo DEPTH.
  - Rejected: the whole bundle is dropped, never partially written. ovf_sticky<=1 and drop_cnt increments.
  - nv=0: no action and no drop.
- Record fields:
  - slot = index of the source slot.
  - exc/intr = that slot's bits.
  - ecause/tval are copied to every record of the bundle.
- Pop: first-word-fall-through.
  - out_valid = (occupancy != 0).
  - out_data = entry[rd_ptr].
  - A pop occurs when out_valid & out_ready; rd_ptr advances by 1.
- Occupancy: next = occupancy + (accepted ? nv : 0) - pop. Simultaneous push and pop both take effect.
- Latency: a record pushed at edge N is visible on out_data after edge N, i.e. in cycle N+1 when the FIFO was empty.
- out_data must hold stable while out_valid=1 and out_ready=0.
- ovf_clr:
  - Clears ovf_sticky at the next edge.
  - If a drop occurs in the same cycle, set wins and ovf_sticky stays 1.
  - ovf_clr does not affect drop_cnt.
- Full (occupancy=DEPTH): out_ready is ignored for the push decision; any nv>=1 bundle drops.
- Empty: out_ready is ignored; no pointer movement.

Optional Feature:
- Macro: SWERV_TRACE_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit counter that increments by 1 per dropped bundle. It saturates at 16'hFFFF and clears only on rst.
- Undefined: no counter register; drop_cnt is tied to 16'h0. ovf_sticky behaviour is unchanged.

Test Plan:
- Reset, then valid=3'b011, insn={..,32'h00A00093,32'h00100013}, addr={..,32'h104,32'h100}, trace_en=1, out_ready=1 -> next cycle record slot=0, insn=32'h00100013, addr=32'h100; following cycle slot=1, addr=32'h104; occupancy returns to 0.
- out_ready=0, push 5 bundles of valid=3'b111 with DEPTH=16 -> occupancy 15 after bundle 5, then 16 if a 1-slot bundle follows; a further 3-slot bundle drops with occupancy unchanged, ovf_sticky=1, drop_cnt=1 (macro on) or 0 (macro off).
- occupancy=14, pop in the same cycle as a 3-slot push -> bundle dropped (no pop credit), occupancy 13 next cycle.
- valid=3'b100, exception=3'b100, ecause=5'd2, tval=32'hDEAD_BEEF -> one record with slot=2, exc=1, ecause=2, tval=DEADBEEF.
- Pointer wrap: stream 40 single-slot records with out_ready toggling 1/0 -> all 40 emerge in order with no loss, and occupancy never exceeds 16.
- Assert rst while occupancy=7 -> out_valid=0 next cycle; ovf_clr together with a drop -> ovf_sticky remains 1.
